sa_out_arbiter: RTL and testbench

Per-output-port switch allocator for the torus router. It arbitrates among the input ports whose route-computed flits target this output, and locks the output to one wormhole packet from head to tail. It tracks downstream credits per VC class and drives the crossbar select and input-side grants. One instance sits behind each output port (six torus directions plus eject), after route computation.

---
 rtl/sa_out_arbiter_pkg.sv | 25 ++
 rtl/sa_out_arbiter_vc_credit_counter.sv | 55 +++++
 rtl/sa_out_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sa_out_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_out_arbiter_pkg.sv
// Shared constants and types for the per-output switch allocator.
//   - flit type codes carried in the flit header
//   - priority-mode selectors for the cmp comparison
//   - number of VC classes tracked by the credit logic
//   - allocator FSM state encoding
package sa_out_arbiter_pkg;

  typedef enum logic [1:0] {
    FlitHead   = 2'd0,
    FlitBody   = 2'd1,
    FlitTail   = 2'd2,
    FlitSingle = 2'd3
  } flit_type_e;

  localparam int unsigned PRIO_FARTHEST = 0;  // larger cmp wins
  localparam int unsigned PRIO_OLDEST   = 1;  // smaller cmp wins

  localparam int unsigned NUM_VC_CLASS = 2;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sa_out_arbiter_vc_credit_counter.sv
// Downstream credit counter for one VC class.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (count resets to Depth)
//   dec       : a flit of this class is sent downstream this cycle
//   inc       : downstream returned one slot of this class
//   count     : current free-slot count
//   nonzero   : count != 0, a flit of this class may be sent
//   overflow  : sticky, a return arrived while the counter was already full
module sa_out_arbiter_vc_credit_counter #(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec,
  input  logic            inc,
  output logic [CntW-1:0] count,
  output logic            nonzero,
  output logic            overflow
);

  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    // A return while full is a protocol error even if a send happens in the same cycle.
    if (inc && (count_q == DepthC)) begin
      overflow_d = 1'b1;
    end
    unique case ({dec, inc})
      2'b10:   count_d = count_q - 1'b1;
      2'b01:   if (count_q != DepthC) count_d = count_q + 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= DepthC;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign nonzero  = (count_q != '0);
  assign overflow = overflow_q;

endmodule

// File: rtl/sa_out_arbiter.sv
// Per-output-port switch allocator. Picks one head flit among the inputs routed here
// (best cmp, round-robin tie-break), then locks the output to that wormhole packet until
// its tail. Tracks downstream credits per VC class.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   req           : input i has a valid flit for this output
//   req_head/tail : flit i is a head / tail (single flit sets both)
//   req_vc        : VC class of flit i
//   req_cmp       : cmp priority field of flit i, slice [i*CMP_W +: CMP_W]
//   credit_ret    : downstream returns one slot of VC class c
//   grant         : one-hot, flit i transfers this cycle (combinational)
//   xbar_sel      : index of granted input, holds last value when idle
//   out_valid     : any grant this cycle
//   out_vc        : VC class of the transferring flit
//   busy          : output locked to a multi-flit packet
//   credit_err    : sticky credit overflow
module sa_out_arbiter
  import sa_out_arbiter_pkg::*;
#(
  parameter int unsigned NUM_IN       = 7,
  parameter int unsigned CMP_W        = 8,
  parameter int unsigned CREDIT_DEPTH = 4,
  parameter int unsigned PRIO_MODE    = PRIO_FARTHEST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN-1:0]         req,
  input  logic [NUM_IN-1:0]         req_head,
  input  logic [NUM_IN-1:0]         req_tail,
  input  logic [NUM_IN-1:0]         req_vc,
  input  logic [NUM_IN*CMP_W-1:0]   req_cmp,
  input  logic [NUM_VC_CLASS-1:0]   credit_ret,
  output logic [NUM_IN-1:0]         grant,
  output logic [$clog2(NUM_IN)-1:0] xbar_sel,
  output logic                      out_valid,
  output logic                      out_vc,
  output logic                      busy,
  output logic                      credit_err
);

  localparam int unsigned SelW = $clog2(NUM_IN);
  localparam int unsigned CntW = $clog2(CREDIT_DEPTH + 1);

  arb_state_e      state_q, state_d;
  logic [SelW-1:0] owner_q, owner_d;
  logic            locked_vc_q, locked_vc_d;
  logic [SelW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SelW-1:0] xbar_sel_q, xbar_sel_d;

  logic [NUM_VC_CLASS-1:0] cred_nz, cred_dec, cred_ovf;
  logic [CntW-1:0]         cred_cnt [NUM_VC_CLASS];

  logic [NUM_IN-1:0] elig;
  logic [CMP_W-1:0]  best_cmp, cur_cmp;
  logic              have_best, win_found;
  logic [SelW-1:0]   win_idx;
  int unsigned       idx;
  logic              grant_vc;

  function automatic logic [SelW-1:0] wrap_inc(input logic [SelW-1:0] p);
    return (p == SelW'(NUM_IN - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar c = 0; c < NUM_VC_CLASS; c++) begin : g_credit
    sa_out_arbiter_vc_credit_counter #(
      .Depth (CREDIT_DEPTH)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .dec      (cred_dec[c]),
      .inc      (credit_ret[c]),
      .count    (cred_cnt[c]),
      .nonzero  (cred_nz[c]),
      .overflow (cred_ovf[c])
    );
  end

  // Counts are exposed by the counter for observability only.
  logic unused_credit_cnt;
  assign unused_credit_cnt = ^{cred_cnt[0], cred_cnt[1]};

  // Head selection among eligible inputs: best cmp, then first at/after rr_ptr.
  always_comb begin
    elig      = '0;
    best_cmp  = '0;
    have_best = 1'b0;
    cur_cmp   = '0;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      elig[i] = req[i] & req_head[i] & cred_nz[req_vc[i]];
    end
    for (int i = 0; i < NUM_IN; i++) begin
      cur_cmp = req_cmp[i*CMP_W +: CMP_W];
      if (elig[i]) begin
        if (!have_best ||
            ((PRIO_MODE == PRIO_OLDEST) ? (cur_cmp < best_cmp) : (cur_cmp > best_cmp))) begin
          best_cmp = cur_cmp;
        end
        have_best = 1'b1;
      end
    end
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      cur_cmp = req_cmp[idx*CMP_W +: CMP_W];
      if (!win_found && elig[idx] && (cur_cmp == best_cmp)) begin
        win_found = 1'b1;
        win_idx   = SelW'(idx);
      end
    end
  end

  // FSM next state and combinational grant outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    locked_vc_d = locked_vc_q;
    rr_ptr_d    = rr_ptr_q;
    grant       = '0;
    grant_vc    = 1'b0;
    xbar_sel_d  = xbar_sel_q;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            grant[win_idx] = 1'b1;
            grant_vc       = req_vc[win_idx];
            xbar_sel_d     = win_idx;
            if (req_tail[win_idx]) begin
              rr_ptr_d = wrap_inc(win_idx);
            end else begin
              state_d     = StLocked;
              owner_d     = win_idx;
              locked_vc_d = req_vc[win_idx];
            end
          end
        end
        StLocked: begin
          if (req[owner_q] && cred_nz[locked_vc_q]) begin
            grant[owner_q] = 1'b1;
            grant_vc       = locked_vc_q;
            xbar_sel_d     = owner_q;
            if (req_tail[owner_q]) begin
              state_d  = StIdle;
              rr_ptr_d = wrap_inc(owner_q);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    cred_dec           = '0;
    cred_dec[grant_vc] = |grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      locked_vc_q <= 1'b0;
      rr_ptr_q    <= '0;
      xbar_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      locked_vc_q <= locked_vc_d;
      rr_ptr_q    <= rr_ptr_d;
      xbar_sel_q  <= xbar_sel_d;
    end
  end

  assign xbar_sel   = xbar_sel_d;
  assign out_valid  = |grant;
  assign out_vc     = grant_vc;
  assign busy       = (state_q == StLocked);
  assign credit_err = |cred_ovf;

endmodule

// File: tb/tb_sa_out_arbiter.sv
module tb_sa_out_arbiter;

  localparam int N     = 7;
  localparam int CW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req, req_head, req_tail, req_vc;
  logic [N*CW-1:0] req_cmp;
  logic [1:0]    credit_ret;
  logic [N-1:0]  grant;
  logic [2:0]    xbar_sel;
  logic          out_valid, out_vc, busy, credit_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sa_out_arbiter #(
    .NUM_IN       (N),
    .CMP_W        (CW),
    .CREDIT_DEPTH (DEPTH),
    .PRIO_MODE    (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_head   (req_head),
    .req_tail   (req_tail),
    .req_vc     (req_vc),
    .req_cmp    (req_cmp),
    .credit_ret (credit_ret),
    .grant      (grant),
    .xbar_sel   (xbar_sel),
    .out_valid  (out_valid),
    .out_vc     (out_vc),
    .busy       (busy),
    .credit_err (credit_err)
  );

  // ---------------- behavioural model ----------------
  bit m_locked = 0;
  int m_owner  = 0;
  int m_lvc    = 0;
  int m_rr     = 0;
  int m_xsel   = 0;
  int m_credit [2] = '{DEPTH, DEPTH};
  bit m_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int cmp_of(input int i);
    return int'(req_cmp[i*CW +: CW]);
  endfunction

  function automatic bit elig(input int i);
    return req[i] && req_head[i] && (m_credit[int'(req_vc[i])] > 0);
  endfunction

  // Input that transfers this cycle per the allocation rules, -1 if none.
  function automatic int model_winner();
    int best;
    bit have;
    best = 0;
    have = 0;
    if (rst) return -1;
    if (m_locked) return (req[m_owner] && m_credit[m_lvc] > 0) ? m_owner : -1;
    for (int i = 0; i < N; i++)
      if (elig(i) && (!have || cmp_of(i) > best)) begin
        best = cmp_of(i);
        have = 1;
      end
    for (int k = 0; k < N; k++)
      if (elig((m_rr + k) % N) && cmp_of((m_rr + k) % N) == best) return (m_rr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int w, vc, nc;
    bit ne;
    if (rst) begin
      m_locked  <= 0;
      m_owner   <= 0;
      m_lvc     <= 0;
      m_rr      <= 0;
      m_xsel    <= 0;
      m_credit  <= '{DEPTH, DEPTH};
      m_err     <= 0;
    end else begin
      w  = model_winner();
      vc = -1;
      if (w >= 0) begin
        vc = m_locked ? m_lvc : int'(req_vc[w]);
        m_xsel <= w;
        if (!m_locked) begin
          if (req_tail[w]) m_rr <= (w + 1) % N;
          else begin
            m_locked <= 1;
            m_owner  <= w;
            m_lvc    <= int'(req_vc[w]);
          end
        end else if (req_tail[w]) begin
          m_locked <= 0;
          m_rr     <= (w + 1) % N;
        end
      end
      ne = m_err;
      for (int c = 0; c < 2; c++) begin
        if (credit_ret[c] && m_credit[c] == DEPTH) ne = 1;
        nc = m_credit[c] - ((vc == c) ? 1 : 0) + (credit_ret[c] ? 1 : 0);
        if (nc > DEPTH) nc = DEPTH;
        m_credit[c] <= nc;
      end
      m_err <= ne;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int w;
    w = model_winner();
    check("grant", int'(grant), (w >= 0) ? (1 << w) : 0);
    check("xbar_sel", int'(xbar_sel), (w >= 0) ? w : m_xsel);
    check("out_valid", int'(out_valid), (w >= 0) ? 1 : 0);
    check("out_vc", int'(out_vc), (w < 0) ? 0 : (m_locked ? m_lvc : int'(req_vc[w])));
    check("busy", int'(busy), int'(m_locked));
    check("credit_err", int'(credit_err), int'(m_err));
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    req        = '0;
    req_head   = '0;
    req_tail   = '0;
    req_vc     = '0;
    req_cmp    = '0;
    credit_ret = '0;
  endtask

  task automatic put(input int i, input bit h, input bit t, input bit vc, input int c);
    req[i]      = 1'b1;
    req_head[i] = h;
    req_tail[i] = t;
    req_vc[i]   = vc;
    req_cmp[i*CW +: CW] = 8'(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("lit_reset_grant", int'(grant), 0);
    check("lit_reset_busy", int'(busy), 0);
    check("lit_reset_xsel", int'(xbar_sel), 0);

    // Priority: cmp 9 beats cmp 3; loser follows next cycle.
    step();
    do_reset();
    put(2, 1, 1, 0, 3);
    put(5, 1, 1, 0, 9);
    #2;
    check("lit_prio_grant", int'(grant), 'h20);
    check("lit_prio_xsel", int'(xbar_sel), 5);
    step();
    put(2, 1, 1, 0, 3);
    #2;
    check("lit_second_grant", int'(grant), 'h04);
    step();
    #2;
    check("lit_idle_xsel_hold", int'(xbar_sel), 2);
    check("lit_idle_valid", int'(out_valid), 0);

    // Round-robin tie-break from rr_ptr=2, then rr_ptr=5 after the tail.
    do_reset();
    put(1, 1, 1, 0, 0);
    #2;
    check("lit_rr_setup", int'(grant), 'h02);
    step();
    put(1, 1, 0, 1, 7);
    put(4, 1, 0, 1, 7);
    #2;
    check("lit_rr_tie", int'(grant), 'h10);
    step();
    put(1, 1, 0, 1, 7);
    put(4, 0, 0, 1, 0);
    #2;
    check("lit_rr_body", int'(grant), 'h10);
    check("lit_rr_busy", int'(busy), 1);
    step();
    put(4, 0, 1, 1, 0);
    #2;
    check("lit_rr_tail", int'(grant), 'h10);
    step();
    put(4, 1, 1, 0, 5);
    put(5, 1, 1, 0, 5);
    #2;
    check("lit_rr_ptr5", int'(grant), 'h20);

    // Lock holds through a 4-flit packet despite a higher-priority head.
    step();
    do_reset();
    put(3, 1, 0, 1, 1);
    #2;
    check("lit_lock_head", int'(grant), 'h08);
    for (int k = 1; k < 4; k++) begin
      step();
      put(3, 0, (k == 3), 1, 0);
      put(0, 1, 1, 0, 200);
      #2;
      check("lit_lock_hold", int'(grant), 'h08);
      check("lit_lock_busy", int'(busy), 1);
    end
    step();
    put(0, 1, 1, 0, 200);
    #2;
    check("lit_lock_release", int'(grant), 'h01);
    check("lit_lock_unbusy", int'(busy), 0);

    // Credit exhaustion and one-cycle credit return latency.
    step();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      put(6, 1, 1, 0, k);
      #2;
      check("lit_credit_use", int'(grant), 'h40);
      step();
    end
    put(6, 1, 1, 0, 0);
    credit_ret = 2'b01;
    #2;
    check("lit_credit_stall", int'(grant), 0);
    step();
    put(6, 1, 1, 0, 0);
    #2;
    check("lit_credit_return", int'(grant), 'h40);

    // Reset mid-packet with credit[1]=1.
    step();
    do_reset();
    put(2, 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      #2;
      check("lit_mid_pkt", int'(grant), 'h04);
      step();
      put(2, 0, 0, 1, 0);
    end
    #1;
    rst = 1'b1;
    #1;
    check("lit_rst_grant", int'(grant), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("lit_rst_busy", int'(busy), 0);
    check("lit_rst_body_ignored", int'(grant), 0);
    for (int k = 0; k < 5; k++) begin
      step();
      put(2, 1, 1, 1, 0);
      #2;
      check("lit_rst_credit", int'(grant), (k < 4) ? 'h04 : 0);
    end

    // Credit overflow is sticky until reset.
    step();
    do_reset();
    credit_ret = 2'b01;
    #2;
    check("lit_err_before", int'(credit_err), 0);
    step();
    #2;
    check("lit_err_set", int'(credit_err), 1);
    repeat (3) step();
    #2;
    check("lit_err_sticky", int'(credit_err), 1);
    do_reset();
    #2;
    check("lit_err_cleared", int'(credit_err), 0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
